// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the EX-stage mul/div/mod sequencer
//
// Operation codes carried on the op port and the sequencer FSM state
// encoding, imported by ex_muldiv_seq and muldiv_step.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
//
// Purely combinational.
// Ports:
//   op       in   operation code; OP_MUL selects shift-add, anything else restoring divide
//   acc      in   2*WIDTH product accumulator
//   rem      in   partial remainder
//   quo      in   shift register: multiplier / dividend bits leave at the MSB,
//                 quotient bits enter at the LSB
//   dsr      in   |multiplicand| or |divisor|
//   acc_nxt, rem_nxt, quo_nxt  out  values after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   rem,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   dsr,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   rem_nxt,
  output logic [WIDTH-1:0]   quo_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           borrow;

  always_comb begin
    // Extra bit keeps the shifted remainder exact when |divisor| = 2^(WIDTH-1).
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {1'b0, dsr};
    borrow  = diff[WIDTH];
    acc_nxt = acc;
    rem_nxt = rem;
    quo_nxt = quo;
    if (op == OP_MUL) begin
      // Multiplier consumed MSB first, so the accumulator doubles each step.
      acc_nxt = (acc << 1) + (quo[WIDTH-1] ? {{WIDTH{1'b0}}, dsr} : {2*WIDTH{1'b0}});
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], ~borrow};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - multi-cycle sequencer for EX-stage mul, div and mod
//
// Accepts one signed operation per handshake, iterates a radix-2 engine for
// WIDTH cycles on |a| and |b|, then applies the sign and presents the result
// until the consumer takes it. Optional build macro MULDIV_EARLY_OUT_EN
// short-circuits trivial operands (a=0, mul by 0, mul/div by +-1) to a
// two-cycle path; results are identical either way.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      operation handshake (op, a, b)
//   op                     00 mul, 01 div, 10 mod, 11 reserved (result 0)
//   a, b                   signed operands
//   flush                  abort any in-flight operation
//   out_valid/out_ready    result handshake (result, div0)
//   result                 product low half, quotient or remainder
//   div0                   div/mod by zero, qualified by out_valid
//   stall                  pipeline hold, high whenever not idle
module ex_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div0,
  output logic             stall
);
  import muldiv_pkg::*;

  state_t             state;
  logic [1:0]         op_r;
  logic               sign_r;
  logic               div0_r;
  logic [WIDTH-1:0]   dsr_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               div_zero;
  logic               sign_in;
  logic               early_go;
  logic [WIDTH-1:0]   early_val;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  logic [WIDTH-1:0]   fix_mag;
  logic               fix_neg;
  logic [WIDTH-1:0]   fix_val;

  // |MIN_INT| is 2^(WIDTH-1), still representable as an unsigned magnitude.
  assign abs_a    = a[WIDTH-1] ? -a : a;
  assign abs_b    = b[WIDTH-1] ? -b : b;
  assign div_zero = ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
  // Remainder takes the dividend's sign; product and quotient take a^b.
  assign sign_in  = (op == OP_MOD) ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);

`ifdef MULDIV_EARLY_OUT_EN
  logic zero_in;
  logic unit_b;
  assign zero_in   = (a == '0) || ((op == OP_MUL) && (b == '0));
  assign unit_b    = ((op == OP_MUL) || (op == OP_DIV)) && (abs_b == WIDTH'(1));
  assign early_go  = zero_in || unit_b;
  // Preloaded as product, quotient and magnitude alike; FIX applies the sign.
  assign early_val = zero_in ? '0 : abs_a;
`else
  assign early_go  = 1'b0;
  assign early_val = '0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .acc     (acc_r),
    .rem     (rem_r),
    .quo     (quo_r),
    .dsr     (dsr_r),
    .acc_nxt (acc_nxt),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_comb begin
    fix_mag = '0;
    case (op_r)
      OP_MUL:  fix_mag = acc_r[WIDTH-1:0];
      OP_DIV:  fix_mag = quo_r;
      OP_MOD:  fix_mag = rem_r;
      default: fix_mag = '0;
    endcase
    // Divide-by-zero quotient is all-ones regardless of operand signs.
    fix_neg = sign_r && !(div0_r && (op_r == OP_DIV));
    fix_val = fix_neg ? -fix_mag : fix_mag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      div0      <= 1'b0;
      stall     <= 1'b0;
      op_r      <= OP_MUL;
      sign_r    <= 1'b0;
      div0_r    <= 1'b0;
      dsr_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      div0      <= 1'b0;
      stall     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r     <= op;
            dsr_r    <= abs_b;
            sign_r   <= sign_in;
            cnt_r    <= CNT_W'(WIDTH);
            in_ready <= 1'b0;
            stall    <= 1'b1;
            if (div_zero) begin
              // Quotient all-ones, remainder |a| (re-signed to a in FIX).
              div0_r <= 1'b1;
              quo_r  <= '1;
              rem_r  <= abs_a;
              acc_r  <= '0;
              state  <= S_FIX;
            end else if (early_go) begin
              div0_r <= 1'b0;
              acc_r  <= {{WIDTH{1'b0}}, early_val};
              quo_r  <= early_val;
              rem_r  <= '0;
              state  <= S_FIX;
            end else begin
              div0_r <= 1'b0;
              acc_r  <= '0;
              rem_r  <= '0;
              quo_r  <= abs_a;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_r <= acc_nxt;
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == CNT_W'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result    <= fix_val;
          div0      <= div0_r;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            div0      <= 1'b0;
            stall     <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
